// File: rtl/reset_sequencer.sv
// Releases per-domain resets one stage at a time: hold interval, release, then wait
// for that stage's acknowledge. Any lost or late acknowledge parks every domain in reset.
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int ACK_TIMEOUT = 1024,
  localparam int KW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_rst_i,
  input  logic [NUM_STAGES-1:0] stage_ack_i,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic                  all_ready_o,
  output logic                  fault_o,
  output logic [KW-1:0]         fault_stage_o
);

  localparam int MAX_CNT = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT_ACK,
    S_READY,
    S_FAULT
  } state_t;

  state_t                r_state;
  logic [KW-1:0]         r_k;
  logic [CW-1:0]         r_cnt;
  logic [NUM_STAGES-1:0] r_stage_rst;
  logic                  r_all_ready;
  logic                  r_fault;
  logic [KW-1:0]         r_fault_stage;

  logic [NUM_STAGES-1:0] w_sel;
  logic [NUM_STAGES-1:0] w_below;
  logic [NUM_STAGES-1:0] w_lost;
  logic [KW-1:0]         w_lost_idx;
  logic                  w_ack_k;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_sel      = '0;
    w_below    = '0;
    w_lost     = '0;
    w_lost_idx = '0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      w_sel[j]   = (r_k == KW'(j));
      w_below[j] = (KW'(j) < r_k);
    end
    // Earlier stages must keep their ack while later ones come up; in READY all must.
    case (r_state)
      S_HOLD, S_WAIT_ACK: w_lost = ~stage_ack_i & w_below;
      S_READY:            w_lost = ~stage_ack_i;
      default:            w_lost = '0;
    endcase
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      if (w_lost[j]) w_lost_idx = KW'(j);
    end
    w_ack_k = |(stage_ack_i & w_sel);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i || req_rst_i) begin
      r_state       <= S_HOLD;
      r_k           <= '0;
      r_cnt         <= '0;
      r_stage_rst   <= '1;
      r_all_ready   <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_stage <= '0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (|w_lost) begin
            r_state       <= S_FAULT;
            r_stage_rst   <= '1;
            r_all_ready   <= 1'b0;
            r_fault       <= 1'b1;
            r_fault_stage <= w_lost_idx;
          end else if (r_cnt == HOLD_LAST) begin
            r_stage_rst <= r_stage_rst & ~w_sel;
            r_cnt       <= '0;
            r_state     <= S_WAIT_ACK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_ACK: begin
          if (|w_lost) begin
            r_state       <= S_FAULT;
            r_stage_rst   <= '1;
            r_all_ready   <= 1'b0;
            r_fault       <= 1'b1;
            r_fault_stage <= w_lost_idx;
          end else if (w_ack_k) begin
            if (r_k == K_LAST) begin
              r_state     <= S_READY;
              r_all_ready <= 1'b1;
            end else begin
              r_k     <= r_k + 1'b1;
              r_cnt   <= '0;
              r_state <= S_HOLD;
            end
          end else if (r_cnt == ACK_LAST) begin
            r_state       <= S_FAULT;
            r_stage_rst   <= '1;
            r_all_ready   <= 1'b0;
            r_fault       <= 1'b1;
            r_fault_stage <= r_k;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_READY: begin
          if (|w_lost) begin
            r_state       <= S_FAULT;
            r_stage_rst   <= '1;
            r_all_ready   <= 1'b0;
            r_fault       <= 1'b1;
            r_fault_stage <= w_lost_idx;
          end
        end
        default: begin
          // FAULT is parked until a request or reset.
          r_state <= S_FAULT;
        end
      endcase
    end
  end

  assign stage_rst_o   = r_stage_rst;
  assign all_ready_o   = r_all_ready;
  assign fault_o       = r_fault;
  assign fault_stage_o = r_fault_stage;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: expected outputs are queued per edge as stimulus is applied and
// compared at the following falling edges for a default and a one-stage instance.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst0, req0, rst1, req1;
  logic [3:0] ack0;
  logic       ack1;
  logic [3:0] st0;
  logic       rdy0, flt0;
  logic [1:0] fs0;
  logic       st1, rdy1, flt1;
  logic       fs1;

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  reset_sequencer dut0 (
    .clk_i(clk), .rst_i(rst0), .req_rst_i(req0), .stage_ack_i(ack0),
    .stage_rst_o(st0), .all_ready_o(rdy0), .fault_o(flt0), .fault_stage_o(fs0)
  );

  reset_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(1), .ACK_TIMEOUT(8)) dut1 (
    .clk_i(clk), .rst_i(rst1), .req_rst_i(req1), .stage_ack_i(ack1),
    .stage_rst_o(st1), .all_ready_o(rdy1), .fault_o(flt1), .fault_stage_o(fs1)
  );

  // Observation vector: {fault_stage[3:0], fault, all_ready, stage_rst[3:0]}
  typedef struct {
    int          sel;
    int          at;
    int          rel;
    string       tag;
    logic [9:0]  exp;
    logic [9:0]  mask;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input int at, input int rel, input string tag,
                      input logic [3:0] st, input logic rdy, input logic flt,
                      input logic [3:0] fs, input logic fs_known);
    exp_t it;
    it.sel  = sel;
    it.at   = at;
    it.rel  = rel;
    it.tag  = tag;
    it.exp  = {fs, flt, rdy, st};
    it.mask = fs_known ? 10'h3FF : 10'h03F;
    sb_q.push_back(it);
  endtask

  // Full default sequence with all acks high, relative to edge 1 = base+1.
  task automatic run_seq(input int base, input logic fs_known, input int upto);
    for (int e = 1; e <= upto; e++) begin
      logic [3:0] st;
      for (int k = 0; k < 4; k++) st[k] = (e < 16 + 17 * k);
      push(0, base + e, e, "seq", st, e >= 68, 1'b0, 4'h0, fs_known);
    end
  endtask

  task automatic wait_until(input int abs_edge);
    while (edge_cnt < abs_edge) @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].at <= edge_cnt) begin
      exp_t       it;
      logic [9:0] obs;
      it  = sb_q.pop_front();
      obs = (it.sel == 0) ? {2'b00, fs0, flt0, rdy0, st0}
                          : {3'b000, fs1, flt1, rdy1, 3'b000, st1};
      check($sformatf("%s@%0d", it.tag, it.rel), 32'(obs & it.mask), 32'(it.exp & it.mask));
    end
  end

  initial begin
    int base;
    rst0 = 1'b1; req0 = 1'b0; ack0 = 4'hF;
    rst1 = 1'b1; req1 = 1'b0; ack1 = 1'b0;
    repeat (2) @(negedge clk);

    base = edge_cnt;
    push(0, base + 1, 0, "reset", 4'hF, 1'b0, 1'b0, 4'h0, 1'b1);
    wait_until(base + 1);

    // Nominal sequence: releases at 16/33/50/67, ready at 68.
    base = edge_cnt; rst0 = 1'b0;
    run_seq(base, 1'b1, 70);
    wait_until(base + 70);

    // Lost acks on stages 1 and 3 while READY; lowest index reported.
    base = edge_cnt; ack0 = 4'b0101;
    push(0, base + 1, 1, "lost_ready", 4'hF, 1'b0, 1'b1, 4'h1, 1'b1);
    push(0, base + 2, 2, "fault_hold", 4'hF, 1'b0, 1'b1, 4'h1, 1'b1);
    wait_until(base + 2);
    base = edge_cnt; ack0 = 4'hF;
    push(0, base + 1, 1, "fault_sticky", 4'hF, 1'b0, 1'b1, 4'h1, 1'b1);
    wait_until(base + 1);

    // Request pulse of three cycles clears the fault, then a full re-sequence.
    base = edge_cnt; req0 = 1'b1;
    for (int i = 1; i <= 3; i++) push(0, base + i, i, "req_clear", 4'hF, 1'b0, 1'b0, 4'h0, 1'b0);
    wait_until(base + 3);
    base = edge_cnt; req0 = 1'b0;
    run_seq(base, 1'b0, 70);
    wait_until(base + 70);

    // Restart, then reset in the middle of stage 2's hold interval.
    base = edge_cnt; req0 = 1'b1;
    push(0, base + 1, 1, "req_restart", 4'hF, 1'b0, 1'b0, 4'h0, 1'b0);
    wait_until(base + 1);
    base = edge_cnt; req0 = 1'b0;
    run_seq(base, 1'b0, 40);
    wait_until(base + 40);
    base = edge_cnt; rst0 = 1'b1;
    push(0, base + 1, 1, "rst_mid", 4'hF, 1'b0, 1'b0, 4'h0, 1'b1);
    push(0, base + 2, 2, "rst_mid", 4'hF, 1'b0, 1'b0, 4'h0, 1'b1);
    wait_until(base + 2);
    base = edge_cnt; rst0 = 1'b0;
    run_seq(base, 1'b1, 70);
    wait_until(base + 70);

    // Stage 2 never acknowledges: release at 50, timeout fault at 1074.
    base = edge_cnt; rst0 = 1'b1; ack0 = 4'b1011;
    push(0, base + 1, 1, "rst_to", 4'hF, 1'b0, 1'b0, 4'h0, 1'b1);
    wait_until(base + 1);
    base = edge_cnt; rst0 = 1'b0;
    push(0, base + 16,   16,   "to_rel0", 4'b1110, 1'b0, 1'b0, 4'h0, 1'b1);
    push(0, base + 33,   33,   "to_rel1", 4'b1100, 1'b0, 1'b0, 4'h0, 1'b1);
    push(0, base + 50,   50,   "to_rel2", 4'b1000, 1'b0, 1'b0, 4'h0, 1'b1);
    push(0, base + 1073, 1073, "to_pre",  4'b1000, 1'b0, 1'b0, 4'h0, 1'b1);
    push(0, base + 1074, 1074, "timeout", 4'hF,    1'b0, 1'b1, 4'h2, 1'b1);
    push(0, base + 1075, 1075, "to_hold", 4'hF,    1'b0, 1'b1, 4'h2, 1'b1);
    wait_until(base + 1075);

    // Lost ack of stage 0 while stage 1 is in its hold interval.
    base = edge_cnt; req0 = 1'b1; ack0 = 4'hF;
    push(0, base + 1, 1, "req_hold", 4'hF, 1'b0, 1'b0, 4'h0, 1'b0);
    wait_until(base + 1);
    base = edge_cnt; req0 = 1'b0;
    push(0, base + 16, 16, "hold_rel0", 4'b1110, 1'b0, 1'b0, 4'h0, 1'b0);
    wait_until(base + 20);
    ack0 = 4'b1110;
    push(0, base + 21, 21, "lost_hold", 4'hF, 1'b0, 1'b1, 4'h0, 1'b1);
    wait_until(base + 21);

    // One stage, hold 1: release at edge 1, ack sampled at edge 7.
    base = edge_cnt;
    push(1, base + 1, 1, "n1_reset", 4'h1, 1'b0, 1'b0, 4'h0, 1'b1);
    wait_until(base + 1);
    base = edge_cnt; rst1 = 1'b0;
    push(1, base + 1, 1, "n1_rel",  4'h0, 1'b0, 1'b0, 4'h0, 1'b1);
    push(1, base + 6, 6, "n1_wait", 4'h0, 1'b0, 1'b0, 4'h0, 1'b1);
    wait_until(base + 6);
    ack1 = 1'b1;
    push(1, base + 7, 7, "n1_ready", 4'h0, 1'b1, 1'b0, 4'h0, 1'b1);
    push(1, base + 8, 8, "n1_ready", 4'h0, 1'b1, 1'b0, 4'h0, 1'b1);
    wait_until(base + 8);

    // Ack arriving on the very timeout sample wins.
    base = edge_cnt; req1 = 1'b1; ack1 = 1'b0;
    wait_until(base + 1);
    base = edge_cnt; req1 = 1'b0;
    push(1, base + 1, 1, "n1_rel2", 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    wait_until(base + 8);
    ack1 = 1'b1;
    push(1, base + 9, 9, "n1_ack_at_to", 4'h0, 1'b1, 1'b0, 4'h0, 1'b0);
    wait_until(base + 9);

    // No ack at all: fault exactly ACK_TIMEOUT edges after release.
    base = edge_cnt; req1 = 1'b1; ack1 = 1'b0;
    wait_until(base + 1);
    base = edge_cnt; req1 = 1'b0;
    push(1, base + 8, 8, "n1_pre_to",  4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
    push(1, base + 9, 9, "n1_timeout", 4'h1, 1'b0, 1'b1, 4'h0, 1'b1);
    wait_until(base + 10);

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
